stream_op_engine: RTL and testbench
===================================

Name: stream_op_engine

Overview:
- Parametrised successor to the nibble-serial FSM ALU: loads two DATA_W operands in CHUNK_W slices, applies a host-driven sequence of 8 accumulate ops, then streams the result out in slices.
- Adds valid/ready handshakes on every stream, an explicit op-last marker, a synchronous abort, a step counter and a last-chunk flag.
- Sits behind the Tiny Tapeout top wrapper; the wrapper maps pins onto it.

Parameters:
- DATA_W, 64, operand/accumulator width; must be a power of two.
- CHUNK_W, 4, slice width per transfer; power of two, ≤ DATA_W.
- STEP_W, 8, width of the saturating step counter.
- Derived: NCHUNK = DATA_W/CHUNK_W; CNT_W = max(1, clog2(NCHUNK)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job (sampled in IDLE only).
- abort  in  1  synchronous return to IDLE.
- in_valid  in  1  operand slice valid.
- in_ready  out  1  engine accepts slice.
- in_a  in  CHUNK_W  operand A slice.
- in_b  in  CHUNK_W  operand B slice.
- op_valid  in  1  op valid.
- op_ready  out  1  engine accepts op.
- op_code  in  3  op select (op_t).
- op_last  in  1  final op of the job.
- out_valid  out  1  result slice valid.
- out_ready  in  1  sink accepts slice.
- out_data  out  CHUNK_W  result slice.
- out_last  out  1  final result slice.
- state_o  out  2  current state (state_t).
- step_count  out  STEP_W  ops applied in the current job.
- busy  out  1  state != IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-low. On reset: state IDLE; A, B, acc, chunk counter and step_count are 0; all outputs are 0.
- Outputs are Moore, decoded from registers:
  - in_ready = (LOAD); op_ready = (EXEC); out_valid = (DRAIN).
  - out_data = acc[cnt*CHUNK_W +: CHUNK_W] when out_valid, else 0.
  - out_last = out_valid && cnt == NCHUNK-1.
- IDLE:
  - start=1 → LOAD next cycle.
  - The same edge clears A, B, acc, cnt and step_count.
- LOAD:
  - Each edge with in_valid writes A[cnt slice]=in_a and B[cnt slice]=in_b, then cnt++. Slices arrive LSB first.
  - The write at cnt==NCHUNK-1 moves to EXEC and resets cnt to 0.
  - in_valid=0 holds all state.
- EXEC:
  - Each edge with op_valid sets acc <= f(op_code, A, B, acc). step_count increments and saturates at all-ones.
  - If op_last is also set, that op is applied and the state moves to DRAIN with cnt=0.
  - One op per cycle, so latency is 1 cycle per op.
- DRAIN:
  - Each edge with out_ready advances cnt.
  - The transfer at cnt==NCHUNK-1 moves to IDLE. acc is held until the next start.
- Ops (all modulo 2^DATA_W; c = acc):
  - 0: (A&B)|c.
  - 1: (A^B)+c.
  - 2: |A−B| ^ c.
  - 3: {c upper half, min(A,B) lower half}.
  - 4: max(A,B)+(c<<1).
  - 5: sat(A+B)&c, where sat clamps to all-ones on carry out.
  - 6: ((A&B)+((A^B)>>1))|c, floor average.
  - 7: rotl1(A)^B^c.
- Priority, highest first: rst, abort, normal transitions.
  - abort forces IDLE next cycle in any state and clears cnt and step_count.
  - abort in IDLE together with start: abort wins and the state stays IDLE.
- start outside IDLE is ignored. Handshake inputs are ignored in states where the matching ready/valid is 0.
- NCHUNK==1: LOAD and DRAIN each take exactly one transfer.
- A reset asserted mid-job returns the block to IDLE immediately; no partial output follows.

Decomposition:
- Package stream_op_pkg:
  - state_t: IDLE=0, LOAD=1, EXEC=2, DRAIN=3.
  - op_t: OP_MASK, OP_XADD, OP_ABSX, OP_MINB, OP_MAXS, OP_SATA, OP_AVGO, OP_ROTX, encoded 0–7.
- Sub-module stream_op_alu #(DATA_W): purely combinational (A, B, acc, op_code) → next_acc, holding all 8 ops.
- stream_op_engine holds the FSM, counters and registers.

Test Plan (DATA_W=16, CHUNK_W=4):
- Load A=0x1234 (slices 4,3,2,1) and B=0x00FF (F,F,0,0); op 1 with last → out slices B,C,2,1 (0x12CB), out_last on the 4th slice, step_count=1, then IDLE.
- A=0xFFF0, B=0x0020; op 0, then op 5+last → acc 0x0020 after op 0, then 0x0020 (saturated 0xFFFF & 0x0020); output 0,2,0,0.
- A=0x0010, B=0x0030; op 2, op 7+last → after op 2 acc=0x0020; op 7 gives 0x0020^0x0030^0x0020=0x0030; output 0,3,0,0.
- Backpressure: in_valid gaps in LOAD and out_ready low 3 cycles in DRAIN → no lost or duplicated slices; out_data stable while stalled.
- abort pulsed after 2 LOAD slices → IDLE next cycle, busy=0; a new job with A=B=0x0001 and op 0+last outputs 0x0001.
- rst deasserted→asserted mid-DRAIN → all outputs 0 immediately; after release, state_o=IDLE and step_count=0.

Source files
------------

// File: rtl/stream_op_pkg.sv
// rtl/stream_op_pkg.sv - shared state and op encodings for the stream op engine
package stream_op_pkg;

  // Engine phases; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Accumulate operations selected by op_code.
  typedef enum logic [2:0] {
    OP_MASK = 3'd0,
    OP_XADD = 3'd1,
    OP_ABSX = 3'd2,
    OP_MINB = 3'd3,
    OP_MAXS = 3'd4,
    OP_SATA = 3'd5,
    OP_AVGO = 3'd6,
    OP_ROTX = 3'd7
  } op_t;

endpackage

// File: rtl/stream_op_alu.sv
// rtl/stream_op_alu.sv - combinational accumulate datapath holding all eight ops
module stream_op_alu
  import stream_op_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] acc,
  input  logic [2:0]        op_code,
  output logic [DATA_W-1:0] next_acc
);

  localparam int HALF = DATA_W / 2;

  logic [DATA_W:0]   sum;
  logic              a_ge_b;
  logic [DATA_W-1:0] min_ab;
  logic [DATA_W-1:0] max_ab;
  logic [DATA_W-1:0] abs_diff;
  logic [DATA_W-1:0] sat_sum;
  logic [DATA_W-1:0] avg_ab;
  logic [DATA_W-1:0] rot_a;

  // Shared operand terms; the carry-free average avoids a DATA_W+1 adder.
  assign sum      = {1'b0, a} + {1'b0, b};
  assign a_ge_b   = (a >= b);
  assign min_ab   = a_ge_b ? b : a;
  assign max_ab   = a_ge_b ? a : b;
  assign abs_diff = a_ge_b ? (a - b) : (b - a);
  assign sat_sum  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  assign avg_ab   = (a & b) + ((a ^ b) >> 1);
  assign rot_a    = {a[DATA_W-2:0], a[DATA_W-1]};

  // Select the accumulate result for the requested op.
  always_comb begin
    next_acc = acc;
    case (op_t'(op_code))
      OP_MASK: next_acc = (a & b) | acc;
      OP_XADD: next_acc = (a ^ b) + acc;
      OP_ABSX: next_acc = abs_diff ^ acc;
      OP_MINB: next_acc = {acc[DATA_W-1:HALF], min_ab[HALF-1:0]};
      OP_MAXS: next_acc = max_ab + (acc << 1);
      OP_SATA: next_acc = sat_sum & acc;
      OP_AVGO: next_acc = avg_ab | acc;
      OP_ROTX: next_acc = rot_a ^ b ^ acc;
      default: next_acc = acc;
    endcase
  end

endmodule

// File: rtl/stream_op_engine.sv
// rtl/stream_op_engine.sv - sliced operand load, op sequencing and sliced result drain
module stream_op_engine
  import stream_op_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 4,
  parameter int STEP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_a,
  input  logic [CHUNK_W-1:0] in_b,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_code,
  input  logic               op_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_last,
  output logic [1:0]         state_o,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  state_t state_q, state_d;

  // Operands and accumulator are viewed as slice arrays so the chunk counter indexes them directly.
  logic [NCHUNK-1:0][CHUNK_W-1:0] a_q, b_q, acc_q;
  logic [DATA_W-1:0]              next_acc;
  logic [CNT_W-1:0]               cnt_q;
  logic [STEP_W-1:0]              step_q;
  logic                           cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  stream_op_alu #(.DATA_W(DATA_W)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .acc      (acc_q),
    .op_code  (op_code),
    .next_acc (next_acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode; abort overrides every normal transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                 state_d = LOAD;
      LOAD:    if (in_valid && cnt_last)  state_d = EXEC;
      EXEC:    if (op_valid && op_last)   state_d = DRAIN;
      DRAIN:   if (out_ready && cnt_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Operand, accumulator, chunk counter and step counter updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      step_q <= '0;
    end else if (abort) begin
      cnt_q  <= '0;
      step_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            step_q <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            a_q[cnt_q] <= in_a;
            b_q[cnt_q] <= in_b;
            cnt_q      <= cnt_last ? '0 : cnt_q + CNT_W'(1);
          end
        end
        EXEC: begin
          if (op_valid) begin
            acc_q  <= next_acc;
            step_q <= (step_q == '1) ? step_q : step_q + STEP_W'(1);
            if (op_last) cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign op_ready   = (state_q == EXEC);
  assign out_valid  = (state_q == DRAIN);
  assign out_data   = out_valid ? acc_q[cnt_q] : '0;
  assign out_last   = out_valid && cnt_last;
  assign state_o    = state_q;
  assign step_count = step_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_stream_op_engine.sv
// tb/tb_stream_op_engine.sv - randomized self-checking bench for stream_op_engine
module tb_stream_op_engine;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int SW = 3;
  localparam int NC = DW / CW;
  localparam int MASK = (1 << DW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic          in_valid = 1'b0, op_valid = 1'b0, op_last = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_a = '0, in_b = '0;
  logic [2:0]    op_code = '0;
  logic          in_ready, op_ready, out_valid, out_last, busy;
  logic [CW-1:0] out_data;
  logic [1:0]    state_o;
  logic [SW-1:0] step_count;

  int checks = 0;
  int failures = 0;
  int ops[16];

  // Reference model, tracked at job level: phase, assembled operands, accumulator, slice index, ops applied.
  int m_phase = 0, m_a = 0, m_b = 0, m_acc = 0, m_idx = 0, m_steps = 0;

  stream_op_engine #(.DATA_W(DW), .CHUNK_W(CW), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_last(op_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .state_o(state_o), .step_count(step_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_op(input int op, input int a, input int b, input int c);
    int r;
    case (op)
      0: r = (a & b) | c;
      1: r = (a ^ b) + c;
      2: r = ((a > b) ? a - b : b - a) ^ c;
      3: r = (c & 'hFF00) | (((a < b) ? a : b) & 'h00FF);
      4: r = ((a > b) ? a : b) + c * 2;
      5: r = (((a + b) > MASK) ? MASK : a + b) & c;
      6: r = ((a + b) / 2) | c;
      default: r = ((a * 2) | (a >> (DW - 1))) ^ b ^ c;
    endcase
    return r & MASK;
  endfunction

  function automatic int fold_ops(input int a, input int b, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c = model_op(ops[i], a, b, c);
    return c;
  endfunction

  // Advance the model on each clock edge from the inputs the engine sees.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_a = 0; m_b = 0; m_acc = 0; m_idx = 0; m_steps = 0;
    end else if (abort) begin
      m_phase = 0; m_idx = 0; m_steps = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_a = 0; m_b = 0; m_acc = 0; m_idx = 0; m_steps = 0;
        end
        1: if (in_valid) begin
          m_a = m_a + (int'(in_a) << (CW * m_idx));
          m_b = m_b + (int'(in_b) << (CW * m_idx));
          m_idx++;
          if (m_idx == NC) begin m_phase = 2; m_idx = 0; end
        end
        2: if (op_valid) begin
          m_acc = model_op(int'(op_code), m_a, m_b, m_acc);
          m_steps++;
          if (op_last) m_phase = 3;
        end
        default: if (out_ready) begin
          m_idx++;
          if (m_idx == NC) begin m_phase = 0; m_idx = 0; end
        end
      endcase
    end
  end

  // Compare every observable output against the model away from the active edge.
  always @(negedge clk) begin
    chk("state_o", int'(state_o), m_phase);
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("in_ready", int'(in_ready), int'(m_phase == 1));
    chk("op_ready", int'(op_ready), int'(m_phase == 2));
    chk("out_valid", int'(out_valid), int'(m_phase == 3));
    chk("out_data", int'(out_data), (m_phase == 3) ? ((m_acc >> (CW * m_idx)) & ((1 << CW) - 1)) : 0);
    chk("out_last", int'(out_last), int'(m_phase == 3 && m_idx == NC - 1));
    chk("step_count", int'(step_count), (m_steps > SMAX) ? SMAX : m_steps);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int a, input int b, input int n, input int gap_pct,
                         input int stall_first, output int result);
    int k, guard;
    result = 0;
    start = 1'b1;
    step();
    for (int i = 0; i < NC; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        start = 1'($urandom); op_valid = 1'($urandom); op_last = 1'($urandom); out_ready = 1'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_a = CW'(a >> (CW * i));
      in_b = CW'(b >> (CW * i));
      start = 1'($urandom); op_valid = 1'($urandom); op_last = 1'($urandom); out_ready = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        op_valid = 1'b0; op_last = 1'($urandom);
        start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
        step();
      end
      op_valid = 1'b1;
      op_code = 3'(ops[i]);
      op_last = (i == n - 1);
      start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      step();
    end
    op_valid = 1'b0; op_last = 1'b0;
    k = 0;
    guard = 0;
    while (k < NC && guard < 200) begin
      out_ready = (guard < stall_first) ? 1'b0 : ($urandom_range(99) >= gap_pct);
      start = 1'($urandom); in_valid = 1'($urandom); op_valid = 1'($urandom);
      if (out_ready && out_valid) begin
        result = result | (int'(out_data) << (CW * k));
        k++;
      end
      step();
      guard++;
    end
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0; op_valid = 1'b0;
    if (k < NC) chk("drain_timeout", k, NC);
  endtask

  initial begin
    int r, n, a, b;

    // Pin the reference model against hand-computed values.
    chk("pin_op1", model_op(1, 'h1234, 'h00FF, 0), 'h12CB);
    chk("pin_op5", model_op(5, 'hFFF0, 'h0020, 'h0020), 'h0020);
    chk("pin_op7", model_op(7, 'h0010, 'h0030, 'h0020), 'h0030);
    chk("pin_op6", model_op(6, 'h1234, 'h5678, 0), 'h3456);
    chk("pin_op3", model_op(3, 'h00F1, 'h0042, 'hAB99), 'hAB42);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'(state_o), 0);
    chk("reset_outs", int'({in_ready, op_ready, out_valid, out_last, busy, out_data}), 0);
    rst = 1'b1;
    step();

    ops[0] = 1;
    run_job('h1234, 'h00FF, 1, 0, 0, r);
    chk("t1_result", r, 'h12CB);
    chk("t1_steps", int'(step_count), 1);
    chk("t1_idle", int'(state_o), 0);

    ops[0] = 0; ops[1] = 5;
    run_job('hFFF0, 'h0020, 2, 0, 0, r);
    chk("t2_result", r, 'h0020);

    ops[0] = 2; ops[1] = 7;
    run_job('h0010, 'h0030, 2, 0, 0, r);
    chk("t3_result", r, 'h0030);

    ops[0] = 6;
    run_job('h1234, 'h5678, 1, 50, 3, r);
    chk("t4_backpressure", r, 'h3456);

    // Abort after two loaded slices, then abort racing start in IDLE.
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_a = 4'h5; in_b = 4'h6; step(); step();
    in_valid = 1'b0; abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_steps", int'(step_count), 0);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    chk("abort_wins", int'(state_o), 0);
    ops[0] = 0;
    run_job('h0001, 'h0001, 1, 0, 0, r);
    chk("t5_after_abort", r, 'h0001);

    // Reset asserted mid-drain.
    ops[0] = 1;
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < NC; i++) begin in_a = 4'hF; in_b = CW'(i); step(); end
    in_valid = 1'b0;
    op_valid = 1'b1; op_code = 3'd1; op_last = 1'b1; step();
    op_valid = 1'b0; op_last = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("pre_reset_drain", int'(out_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_outs", int'({in_ready, op_ready, out_valid, out_last, busy, out_data}), 0);
    chk("rst_state", int'(state_o), 0);
    step();
    #2 rst = 1'b1;
    step();
    chk("post_rst_state", int'(state_o), 0);
    chk("post_rst_steps", int'(step_count), 0);

    // Randomized jobs, including op counts beyond the step counter range.
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(10, 1);
      a = $urandom_range(MASK);
      b = $urandom_range(MASK);
      for (int i = 0; i < n; i++) ops[i] = $urandom_range(7);
      run_job(a, b, n, 30, $urandom_range(3), r);
      chk("rand_result", r, fold_ops(a, b, n));
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
